// File: rtl/fight_referee_pkg.sv
// Shared game definitions: referee states, winner codes, health and action constants.
package fight_referee_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FIGHT, S_ROUND_END, S_MATCH_END
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    ACT_IDLE, ACT_PUNCH, ACT_KICK, ACT_BLOCK
  } action_e;

  localparam logic [1:0] HEALTH_KO  = 2'd0;
  localparam logic [1:0] HEALTH_MAX = 2'd3;
  localparam logic [1:0] WINS_SAT   = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == WINS_SAT) ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/fight_referee_if.sv
// Game-side bus between the referee and the rest of the game (player health in, match status out).
interface fight_referee_if;
  logic       start;
  logic       game_tick;
  logic [1:0] left_health;
  logic [1:0] right_health;
  logic       players_rst_n;
  logic       fight_active;
  logic [2:0] round_num;
  logic [1:0] left_wins;
  logic [1:0] right_wins;
  logic [5:0] round_timer;
  logic       match_over;
  logic [1:0] winner;

  modport master (
    output start, game_tick, left_health, right_health,
    input  players_rst_n, fight_active, round_num, left_wins, right_wins,
           round_timer, match_over, winner
  );

  modport slave (
    input  start, game_tick, left_health, right_health,
    output players_rst_n, fight_active, round_num, left_wins, right_wins,
           round_timer, match_over, winner
  );
endinterface

// File: rtl/fight_referee_tick_timer.sv
// Round countdown: parallel load, decrement on enable, stops at zero.
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           count <= '0;
    else if (load)        count <= load_val;
    else if (en && !zero) count <= count - W'(1);
  end
endmodule

// File: rtl/fight_referee.sv
// Match referee: sequences rounds, judges KO/timeout, tallies wins and declares the match winner.
module fight_referee
  import fight_referee_pkg::*;
#(
  parameter int ROUND_TICKS = 60,
  parameter int WINS_NEEDED = 2,
  parameter int MAX_ROUNDS  = 5,
  parameter int PAUSE_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fight_referee_if.slave  bus
);
  localparam logic [5:0] TIMER_LOAD  = 6'(ROUND_TICKS);
  localparam logic [7:0] PAUSE_LAST  = 8'(PAUSE_TICKS - 1);
  localparam logic [2:0] ROUND_LIMIT = 3'(MAX_ROUNDS);
  localparam logic [1:0] WINS_TARGET = 2'(WINS_NEEDED);

  state_e     state;
  logic       setup_cnt;
  logic [7:0] pause_cnt;
  logic       players_rst_n_q, fight_active_q, match_over_q;
  logic [2:0] round_num_q;
  logic [1:0] left_wins_q, right_wins_q;
  winner_e    winner_q;

  logic [5:0] timer_count;
  logic       timer_zero, timer_load, timer_en;
  logic       round_done, match_done;
  winner_e    round_res, final_winner;

  assign timer_load = (state == S_SETUP) && setup_cnt;
  assign timer_en   = (state == S_FIGHT) && bus.game_tick;

  tick_timer #(.W(6)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(timer_load), .load_val(TIMER_LOAD),
    .en(timer_en), .count(timer_count), .zero(timer_zero)
  );

  // KO is judged first, so a knockout on the last tick never falls through to the timeout compare.
  always_comb begin
    round_done = 1'b0;
    round_res  = WIN_NONE;
    if (bus.left_health == HEALTH_KO || bus.right_health == HEALTH_KO) begin
      round_done = 1'b1;
      if (bus.left_health == HEALTH_KO && bus.right_health == HEALTH_KO) round_res = WIN_DRAW;
      else if (bus.left_health == HEALTH_KO)                             round_res = WIN_RIGHT;
      else                                                               round_res = WIN_LEFT;
    end else if (timer_count == 6'd1 || timer_zero) begin
      round_done = 1'b1;
      if (bus.left_health > bus.right_health)      round_res = WIN_LEFT;
      else if (bus.left_health < bus.right_health) round_res = WIN_RIGHT;
      else                                         round_res = WIN_DRAW;
    end
  end

  // Whoever reached the target necessarily has more wins, so one compare covers both end conditions.
  always_comb begin
    match_done = (left_wins_q == WINS_TARGET) || (right_wins_q == WINS_TARGET) ||
                 (round_num_q == ROUND_LIMIT);
    if (left_wins_q > right_wins_q)      final_winner = WIN_LEFT;
    else if (left_wins_q < right_wins_q) final_winner = WIN_RIGHT;
    else                                 final_winner = WIN_DRAW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      setup_cnt       <= 1'b0;
      pause_cnt       <= '0;
      players_rst_n_q <= 1'b0;
      fight_active_q  <= 1'b0;
      round_num_q     <= '0;
      left_wins_q     <= '0;
      right_wins_q    <= '0;
      match_over_q    <= 1'b0;
      winner_q        <= WIN_NONE;
    end else begin
      case (state)
        S_IDLE, S_MATCH_END: if (bus.start) begin
          state           <= S_SETUP;
          setup_cnt       <= 1'b0;
          players_rst_n_q <= 1'b0;
          round_num_q     <= 3'd1;
          left_wins_q     <= '0;
          right_wins_q    <= '0;
          match_over_q    <= 1'b0;
          winner_q        <= WIN_NONE;
        end
        S_SETUP: begin
          if (setup_cnt) begin
            state           <= S_FIGHT;
            players_rst_n_q <= 1'b1;
            fight_active_q  <= 1'b1;
          end else begin
            setup_cnt <= 1'b1;
          end
        end
        S_FIGHT: if (timer_en && round_done) begin
          state          <= S_ROUND_END;
          fight_active_q <= 1'b0;
          pause_cnt      <= '0;
          case (round_res)
            WIN_LEFT:  left_wins_q  <= sat_inc(left_wins_q);
            WIN_RIGHT: right_wins_q <= sat_inc(right_wins_q);
            default: ;
          endcase
        end
        S_ROUND_END: if (bus.game_tick) begin
          if (pause_cnt == PAUSE_LAST) begin
            if (match_done) begin
              state        <= S_MATCH_END;
              match_over_q <= 1'b1;
              winner_q     <= final_winner;
            end else begin
              state           <= S_SETUP;
              setup_cnt       <= 1'b0;
              players_rst_n_q <= 1'b0;
              round_num_q     <= round_num_q + 3'd1;
            end
          end else begin
            pause_cnt <= pause_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.players_rst_n = players_rst_n_q;
  assign bus.fight_active  = fight_active_q;
  assign bus.round_num     = round_num_q;
  assign bus.left_wins     = left_wins_q;
  assign bus.right_wins    = right_wins_q;
  assign bus.round_timer   = timer_count;
  assign bus.match_over    = match_over_q;
  assign bus.winner        = winner_q;
endmodule

// File: doc/fight_referee.md
FIGHT_REFEREE -- requirements
Module: fight_referee

Interface
REQ-001 SHALL have parameter ROUND_TICKS, default 60: game ticks per round.
REQ-002 SHALL have parameter WINS_NEEDED, default 2: round wins that end the match.
REQ-003 SHALL have parameter MAX_ROUNDS, default 5: hard round limit per match.
REQ-004 SHALL have parameter PAUSE_TICKS, default 8: game ticks between rounds.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a match.
REQ-008 SHALL have port game_tick  input  1  one-cycle strobe, one per game step.
REQ-009 SHALL have ports left_health, right_health  input  2 each  present health from the player stages.
REQ-010 SHALL have port players_rst_n  output  1  active-low reset driven to both player stages.
REQ-011 SHALL have port fight_active  output  1  high while a round is in play.
REQ-012 SHALL have port round_num  output  3  current round, 1-based; 0 when idle.
REQ-013 SHALL have ports left_wins, right_wins  output  2 each  round wins this match.
REQ-014 SHALL have port round_timer  output  6  ticks remaining in the current round.
REQ-015 SHALL have port match_over  output  1  high in MATCH_END.
REQ-016 SHALL have port winner  output  2  00 none, 01 left, 10 right, 11 draw; valid while match_over.

Function
REQ-017 SHALL implement a state machine with states IDLE, SETUP, FIGHT, ROUND_END, MATCH_END.
REQ-018 IDLE: start moves to SETUP, clears both win counters, sets round_num to 1.
REQ-019 SETUP: SHALL drive players_rst_n low for exactly 2 clocks, load round_timer with ROUND_TICKS, then enter FIGHT; players_rst_n is high in all other states.
REQ-020 FIGHT: fight_active high; on each game_tick, health is sampled and round_timer decrements by 1.
REQ-021 KO: a sampled health of 0 ends the round on that tick; if both are 0 on the same tick, the round is a draw.
REQ-022 Timeout: when round_timer reaches 0 with no KO, the player with higher health wins the round; equal health is a draw.
REQ-023 KO SHALL take priority over timeout on the same tick.
REQ-024 Round winner's counter SHALL increment by 1 on entry to ROUND_END; a draw increments neither; counters saturate at 3.
REQ-025 ROUND_END: SHALL wait PAUSE_TICKS game_ticks, then go to MATCH_END if either counter equals WINS_NEEDED or round_num equals MAX_ROUNDS; otherwise increment round_num and go to SETUP.
REQ-026 MATCH_END: winner = side with WINS_NEEDED wins; at the round limit, side with more wins; equal counts give 11.
REQ-027 MATCH_END: start SHALL begin a new match exactly as REQ-018; winner returns to 00.
REQ-028 start outside IDLE and MATCH_END SHALL be ignored.
REQ-029 game_tick outside FIGHT and ROUND_END SHALL have no effect.
REQ-030 start and game_tick together in IDLE: only start acts; the tick is not counted.
REQ-031 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-032 rst_n low SHALL force IDLE immediately from any state, including mid-round.
REQ-033 Reset values: players_rst_n 0, fight_active 0, round_num 0, wins 0, round_timer 0, match_over 0, winner 00.
REQ-034 players_rst_n SHALL remain 0 while in IDLE after reset, so player stages hold reset until a match starts.

Structure
REQ-035 State encodings, winner codes (NONE/LEFT/RIGHT/DRAW) and health constants SHALL live in a shared game package, alongside the action codes.
REQ-036 The round timer SHALL be a sub-module, tick_timer: load, decrement on enable, zero flag.

Verification
REQ-037 start, then left_health forced to 0 on the 5th tick -> right_wins=1, ROUND_END for 8 ticks, SETUP holds players_rst_n low 2 clocks, round_num=2.
REQ-038 Both healths 0 on the same tick -> draw round, wins unchanged, round_num advances.
REQ-039 60 ticks with left=3, right=1 -> timeout, left_wins increments; with equal healths -> draw.
REQ-040 Right wins rounds 1 and 2 -> MATCH_END, match_over=1, winner=10; start -> round_num=1, wins 0, winner 00.
REQ-041 Five draws -> MATCH_END after round 5, winner=11.
REQ-042 rst_n pulsed mid-FIGHT with round_timer=30 -> all outputs at reset values; start mid-FIGHT -> no effect.
